md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 start  input  1  EX-stage MD instruction valid this cycle.
REQ-006 op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved (no-op).
REQ-007 a  input  32  rs operand from EX forwarding mux.
REQ-008 b  input  32  rt operand from EX forwarding mux.
REQ-009 idUsesMD  input  1  ID-stage instruction is mult/div/mthi/mtlo/mfhi/mflo.
REQ-010 rdSel  input  1  mfhi/mflo read select: 0 LO, 1 HI.
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 stall  output  1  freeze PC and IF/ID, bubble ID/EX.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.
REQ-015 mdOut  output  32  rdSel ? hi : lo, combinational.

Function
REQ-016 State machine SHALL have states IDLE, MUL, DIV; busy=1 only in MUL or DIV.
REQ-017 In IDLE, start with op 0/1 SHALL latch a, b, signedness, go to MUL, load counter with MULT_CYCLES.
REQ-018 In IDLE, start with op 2/3 SHALL latch a, b, signedness, go to DIV, load counter with DIV_CYCLES.
REQ-019 In MUL/DIV, counter SHALL decrement each cycle; at edge where counter==1, SHALL write HI/LO, return to IDLE; busy deasserts that edge.
REQ-020 Result: mult/multu {hi,lo}=64-bit signed/unsigned product; div/divu lo=quotient, hi=remainder, truncation toward zero, remainder takes dividend sign.
REQ-021 Division by zero SHALL leave HI and LO unchanged; busy timing identical to normal div.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-023 In IDLE, start with op 4/5 SHALL write a into HI/LO at next edge, no busy.
REQ-024 start while busy=1 SHALL be ignored, all ops including mthi/mtlo.
REQ-025 Operand latches SHALL not change during MUL/DIV; a/b changes then have no effect.
REQ-026 stall SHALL equal idUsesMD & (busy | (start & op is 0-3)), combinational.
REQ-027 mdOut SHALL reflect committed HI/LO only; no bypass of in-flight results.
REQ-028 Reserved op with start SHALL change no state.

Reset
REQ-029 With reset=0 at rising edge: state IDLE, counter 0, busy 0, hi 0, lo 0, operand latches 0.
REQ-030 Reset mid-operation SHALL abort the operation without any HI/LO write.
REQ-031 stall SHALL be 0 from the first cycle after reset while start=0.

Configuration
REQ-032 Macro MD_DIV_EN defined: div/divu behave per REQ-018..REQ-022.
REQ-033 Macro MD_DIV_EN undefined: op 2/3 treated as reserved per REQ-028; DIV state and divider logic absent; stall never raised for them.

Verification
REQ-034 mult a=0xFFFFFFFF b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
REQ-035 multu a=0xFFFFFFFF b=2 -> after 5 cycles hi=0x00000001 lo=0xFFFFFFFE.
REQ-036 div a=-7 b=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; div b=0 -> hi/lo unchanged.
REQ-037 mult start with idUsesMD=1 held -> stall=1 on start cycle and all 5 busy cycles, 0 after; mthi 0x1234 at cycle 2 of busy -> hi unaffected.
REQ-038 reset=0 at busy cycle 3 of div -> busy 0 next cycle, hi=lo=0, no later write.
REQ-039 Without MD_DIV_EN, divu a=10 b=3 -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/md_ctrl.sv
// Multiply/divide unit with HI/LO registers, busy counter and pipeline stall.
// Define MD_DIV_EN to build the divider and the DIV state; otherwise div/divu are no-ops.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        idUsesMD,
  input  logic        rdSel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef MD_DIV_EN
  localparam logic [1:0] ST_DIV  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             sign_q, sign_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  logic             op_mul_s, op_div_s, op_signed_s, done_s;
  logic [63:0]      mul_a_s, mul_b_s, prod_s;
`ifdef MD_DIV_EN
  logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
  logic               div_unused_s;
`endif

  // Opcode decode; even opcodes of each pair are the signed variants
  always_comb begin
    op_mul_s    = (op == 3'd0) || (op == 3'd1);
`ifdef MD_DIV_EN
    op_div_s    = (op == 3'd2) || (op == 3'd3);
`else
    op_div_s    = 1'b0;
`endif
    op_signed_s = ~op[0];
  end

  // Arithmetic on latched operands; 64-bit product of extended operands covers both signednesses
  always_comb begin
    mul_a_s = sign_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    mul_b_s = sign_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod_s  = mul_a_s * mul_b_s;
`ifdef MD_DIV_EN
    // 33-bit signed divide makes 0x80000000 / -1 representable and unsigned ops uniform
    dvd_s        = sign_q ? {a_q[31], a_q} : {1'b0, a_q};
    dvs_s        = (b_q == 32'd0) ? 33'sd1 : (sign_q ? {b_q[31], b_q} : {1'b0, b_q});
    quo_s        = dvd_s / dvs_s;
    rem_s        = dvd_s % dvs_s;
    div_unused_s = quo_s[32] ^ rem_s[32];
`endif
  end

  // State register plus datapath flops, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sign_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && op_mul_s) begin
          state_d = ST_MUL;
          cnt_d   = CNT_W'(MULT_CYCLES);
        end else if (start && op_div_s) begin
`ifdef MD_DIV_EN
          state_d = ST_DIV;
          cnt_d   = CNT_W'(DIV_CYCLES);
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef MD_DIV_EN
      ST_DIV,
`endif
      ST_MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Operand latch and HI/LO update; starts while busy are ignored
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sign_d = sign_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (state_q == ST_IDLE) begin
      if (start && (op_mul_s || op_div_s)) begin
        a_d    = a;
        b_d    = b;
        sign_d = op_signed_s;
      end else if (start && (op == 3'd4)) begin
        hi_d = a;
      end else if (start && (op == 3'd5)) begin
        lo_d = a;
      end else begin
        hi_d = hi_q;
      end
    end else if (done_s) begin
      case (state_q)
        ST_MUL: begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end
`ifdef MD_DIV_EN
        ST_DIV: begin
          if (b_q != 32'd0) begin
            hi_d = rem_s[31:0];
            lo_d = quo_s[31:0];
          end else begin
            hi_d = hi_q;
          end
        end
`endif
        default: hi_d = hi_q;
      endcase
    end else begin
      hi_d = hi_q;
    end
  end

  // Outputs
  always_comb begin
    busy  = (state_q != ST_IDLE);
    stall = idUsesMD & (busy | (start & (op_mul_s | op_div_s)));
    hi    = hi_q;
    lo    = lo_q;
    mdOut = rdSel ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed and random ops against an arithmetic reference model.
module tb_md_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, idUsesMD, rdSel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall;
  logic [31:0] hi, lo, mdOut;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .idUsesMD(idUsesMD), .rdSel(rdSel), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo), .mdOut(mdOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit is_long(input logic [2:0] o);
`ifdef MD_DIV_EN
    return (o <= 3'd3);
`else
    return (o <= 3'd1);
`endif
  endfunction

  // Architectural result of one instruction, computed with wide integer arithmetic
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       inout logic [31:0] h, inout logic [31:0] l);
    logic [63:0] p;
    longint      sx, sy, q, r;
    int          ix, iy;
    ix = x;
    iy = y;
    case (o)
      3'd0: begin sx = ix; sy = iy; p = sx * sy; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; l = p[31:0]; end
`ifdef MD_DIV_EN
      3'd2, 3'd3: begin
        if (y != 32'd0) begin
          if (o == 3'd2) begin sx = ix; sy = iy; end
          else begin sx = {32'd0, x}; sy = {32'd0, y}; end
          q = sx / sy;
          r = sx % sy;
          h = r[31:0];
          l = q[31:0];
        end
      end
`endif
      3'd4: h = x;
      3'd5: l = x;
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag, input bit exp_busy, input bit exp_stall);
    rdSel = 1'($urandom_range(0, 1));
    #1;
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_mdout"}, mdOut, rdSel ? exp_hi : exp_lo);
  endtask

  // Issue one op, then follow it cycle by cycle; intr >= 0 injects an ignored start mid-busy
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit uses, input int intr);
    logic [31:0] nh, nl;
    int          n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; idUsesMD = uses;
    #1;
    chk("stall_start", {31'd0, stall}, {31'd0, uses & is_long(o)});
    chk("busy_start", {31'd0, busy}, 32'd0);
    nh = exp_hi;
    nl = exp_lo;
    model(o, x, y, nh, nl);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    if (is_long(o)) begin
      n = (o <= 3'd1) ? MC : DC;
      for (int i = 0; i < n; i++) begin
        check_state("inflight", 1'b1, uses);
        if (i == intr) begin
          start = 1'b1;
          op    = 3'($urandom_range(0, 5));
          a     = 32'h0000_1234;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    exp_hi = nh;
    exp_lo = nl;
    check_state("done", 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    idUsesMD = 1'b1; rdSel = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset", 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_state("post_reset", 1'b0, 1'b0);

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1, -1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    run_op(3'd0, 32'd3, 32'd5, 1'b1, 1);
    run_op(3'd4, 32'hA5A5_0001, 32'd0, 1'b1, -1);
    run_op(3'd5, 32'h5A5A_0002, 32'd0, 1'b0, -1);
    run_op(3'd6, 32'h1111_1111, 32'd0, 1'b1, -1);
    run_op(3'd7, 32'h2222_2222, 32'd0, 1'b1, -1);
`ifdef MD_DIV_EN
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, -1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'd2, 32'd5, 32'd0, 1'b0, -1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 3);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd7, 1'b1, -1);
`else
    run_op(3'd3, 32'd10, 32'd3, 1'b1, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, -1);
`endif

    for (int k = 0; k < 24; k++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)),
             $urandom_range(0, 1) != 0 ? int'($urandom_range(0, MC - 1)) : -1);
    end

    // Reset during the third busy cycle aborts the operation
    @(negedge clk);
`ifdef MD_DIV_EN
    op = 3'd2;
`else
    op = 3'd0;
`endif
    start = 1'b1; a = 32'h1234_5678; b = 32'd3; idUsesMD = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check_state("rst_abort", 1'b0, 1'b0);
    repeat (DC + 2) @(negedge clk);
    check_state("rst_nowrite", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
